// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and frame geometry for the TDM demultiplexer.
// Define TDM_PARITY_EN to add a ninth, even-parity slot to every frame.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

`ifdef TDM_PARITY_EN
    localparam int SLOTS_PER_FRAME = 9;
    localparam int SEL_W           = 4;
`else
    localparam int SLOTS_PER_FRAME = 8;
    localparam int SEL_W           = 3;
`endif

    localparam int LAST_SLOT = SLOTS_PER_FRAME - 1;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index counter, modulo SLOTS_PER_FRAME, with clear, sync-load to 1 and advance.
// Frame length follows TDM_PARITY_EN through tdm_pkg.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic             adv,
    output logic [SEL_W-1:0] sel
);

    // Clear wins over load so a sync-loss drop always parks the index at 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sel <= '0;
        else if (clr) sel <= '0;
        else if (load) sel <= SEL_W'(1);
        else if (adv) sel <= (sel == SEL_W'(LAST_SLOT)) ? '0 : sel + SEL_W'(1);
    end

endmodule

// File: rtl/tdm_one_to_eight_demux.sv
// tdm_one_to_eight_demux: serial TDM to 8-bit parallel demultiplexer with frame-sync tracking.
// Define TDM_PARITY_EN for 9-slot frames whose last slot carries even parity over slots 0..7.
module tdm_one_to_eight_demux
    import tdm_pkg::*;
#(
    parameter int SYNC_MISS_MAX = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             sync,
    input  logic             din,
    output logic [7:0]       d,
    output logic             valid,
    output logic [SEL_W-1:0] sel,
    output logic             lock,
    output logic             err
);

    state_t     state;
    logic [7:0] hold;
    logic [2:0] miss;
    logic       locked;
    logic       at_zero;
    logic       last;
    logic       drop;

    assign locked  = state == LOCKED;
    assign lock    = locked;
    assign at_zero = sel == '0;
    assign last    = sel == SEL_W'(LAST_SLOT);
    // A missing sync at a frame boundary that exhausts the tolerance forces a return to HUNT.
    assign drop    = locked && !sync && at_zero && (miss + 3'd1 == 3'(SYNC_MISS_MAX));

    tdm_slot_counter u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .clr  (en && drop),
        .load (en && sync),
        .adv  (en && locked),
        .sel  (sel)
    );

    // Lock FSM, slot capture and registered frame/pulse outputs; pulses default low each cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= HUNT;
            d     <= 8'h00;
            valid <= 1'b0;
            err   <= 1'b0;
            hold  <= 8'h00;
            miss  <= 3'd0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (en) begin
                if (!locked) begin
                    if (sync) begin
                        state <= LOCKED;
                        hold  <= {7'd0, din};
                        miss  <= 3'd0;
                    end
                end else if (sync) begin
                    hold <= {7'd0, din};
                    miss <= 3'd0;
                    err  <= !at_zero;
                end else if (at_zero) begin
                    err  <= 1'b1;
                    miss <= miss + 3'd1;
                    if (drop) state <= HUNT;
                    else hold <= {7'd0, din};
                end else begin
`ifdef TDM_PARITY_EN
                    if (last) begin
                        if (din == ^hold) begin
                            d     <= hold;
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        hold[sel[2:0]] <= din;
                    end
`else
                    hold[sel] <= din;
                    if (last) begin
                        d     <= {din, hold[6:0]};
                        valid <= 1'b1;
                    end
`endif
                end
            end
        end
    end

endmodule
